// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 codes, the
// memory sign_mask encoding and the handshake FSM state encoding.
package lsu_pkg;

  // RISC-V load funct3 codes; SB/SH/SW reuse the LB/LH/LW codes.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Size field of the memory sign_mask (bits [2:0]).
  localparam logic [2:0] MASK_B = 3'b001;
  localparam logic [2:0] MASK_H = 3'b011;
  localparam logic [2:0] MASK_W = 3'b111;

  // sign_mask bit that requests sign extension from the memory.
  localparam int MASK_EXT_BIT = 3;

  // Handshake FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_mask_gen.sv
// Combinational funct3 decoder: produces the memory sign_mask, a legality
// flag for the funct3 code, and a natural-alignment flag from addr[1:0].
module lsu_mask_gen
  import lsu_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] sign_mask_o,
  output logic       legal_o,
  output logic       misaligned_o
);

  // Decode access size/extension and check alignment for the requested size.
  always_comb begin
    sign_mask_o  = 4'b0000;
    legal_o      = 1'b0;
    misaligned_o = 1'b0;
    case (funct3_i)
      F3_LB: begin
        sign_mask_o               = {1'b0, MASK_B};
        sign_mask_o[MASK_EXT_BIT] = 1'b1;
        legal_o                   = 1'b1;
      end
      F3_LH: begin
        sign_mask_o               = {1'b0, MASK_H};
        sign_mask_o[MASK_EXT_BIT] = 1'b1;
        legal_o                   = 1'b1;
        misaligned_o              = addr_lo_i[0];
      end
      F3_LW: begin
        // A full word needs no extension, so the extend bit stays clear.
        sign_mask_o  = {1'b0, MASK_W};
        legal_o      = 1'b1;
        misaligned_o = (addr_lo_i != 2'b00);
      end
      F3_LBU: begin
        sign_mask_o = {1'b0, MASK_B};
        legal_o     = 1'b1;
      end
      F3_LHU: begin
        sign_mask_o  = {1'b0, MASK_H};
        legal_o      = 1'b1;
        misaligned_o = addr_lo_i[0];
      end
      default: begin
        sign_mask_o  = 4'b0000;
        legal_o      = 1'b0;
        misaligned_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and the data memory. Accepts one
// access at a time, issues a single memread/memwrite strobe, follows the
// memory's busy (clk_stall) pulse, returns load data and aborts a lost
// handshake after TIMEOUT_CYCLES.
// Optional build macro: LSU_MISALIGN_TRAP_EN -- traps misaligned halfword/
// word accesses and illegal funct3 codes with a one-cycle err_misalign pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  input  logic              req_write_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              pipe_stall_o,
  output logic              load_valid_o,
  output logic [31:0]       load_data_o,
  output logic              err_timeout_o,
  output logic              err_misalign_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              mem_memread_o,
  output logic              mem_memwrite_o,
  output logic [3:0]        mem_sign_mask_o,
  input  logic              mem_stall_i,
  input  logic [31:0]       mem_rdata_i
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  lsu_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              write_q;
  logic [3:0]        mask_q;
  logic [31:0]       load_data_q;
  logic              load_valid_q;
  logic              err_timeout_q;
  logic              err_misalign_q;
  logic              seen_busy_q;
  logic              stall_prev_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [3:0]        dec_mask_s;
  logic              legal_s;
  logic              misaligned_s;
  logic              accept_s;
  logic              issue_go_s;

  lsu_mask_gen u_mask_gen (
    .funct3_i     (req_funct3_i),
    .addr_lo_i    (req_addr_i[1:0]),
    .sign_mask_o  (dec_mask_s),
    .legal_o      (legal_s),
    .misaligned_o (misaligned_s)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign accept_s = legal_s & ~misaligned_s;
`else
  // Misaligned accesses go to memory unchanged; the flag is not needed.
  logic unused_misalign_s;
  assign unused_misalign_s = misaligned_s;
  assign accept_s          = legal_s;
`endif

  // The strobe waits for a memory that was still busy in the previous
  // cycle. Using the registered busy flag keeps mem_stall off the strobe's
  // combinational path, so a memory that raises clk_stall from memread
  // cannot form a loop.
  assign issue_go_s = (state_q == ST_ISSUE) && !stall_prev_q;

  // Handshake FSM, timeout counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      wdata_q        <= 32'h0000_0000;
      write_q        <= 1'b0;
      mask_q         <= 4'b0000;
      load_data_q    <= 32'h0000_0000;
      load_valid_q   <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_misalign_q <= 1'b0;
      seen_busy_q    <= 1'b0;
      stall_prev_q   <= 1'b0;
      cnt_q          <= '0;
    end else begin
      load_valid_q   <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_misalign_q <= 1'b0;
      stall_prev_q   <= mem_stall_i;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i && accept_s) begin
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            write_q <= req_write_i;
            mask_q  <= dec_mask_s;
            cnt_q   <= '0;
            state_q <= ST_ISSUE;
          end else begin
`ifdef LSU_MISALIGN_TRAP_EN
            err_misalign_q <= req_valid_i;
`endif
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (issue_go_s) begin
            // The strobe cycle itself counts toward the timeout window.
            cnt_q       <= CNT_ONE;
            seen_busy_q <= 1'b0;
            state_q     <= ST_WAIT;
          end else if (cnt_q == CNT_LAST) begin
            err_timeout_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_WAIT: begin
          if (seen_busy_q && !mem_stall_i) begin
            if (!write_q) begin
              load_data_q  <= mem_rdata_i;
              load_valid_q <= 1'b1;
            end
            state_q <= ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            err_timeout_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
            if (mem_stall_i) begin
              seen_busy_q <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall rises in the acceptance cycle and covers ISSUE and WAIT.
  assign pipe_stall_o    = ((state_q == ST_IDLE) && req_valid_i && accept_s) ||
                           (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign mem_memread_o   = issue_go_s && !write_q;
  assign mem_memwrite_o  = issue_go_s && write_q;
  assign mem_addr_o      = addr_q;
  assign mem_wdata_o     = wdata_q;
  assign mem_sign_mask_o = mask_q;
  assign load_valid_o    = load_valid_q;
  assign load_data_o     = load_data_q;
  assign err_timeout_o   = err_timeout_q;
  assign err_misalign_o  = err_misalign_q;

endmodule
